issuer: RTL and testbench

ISSUER -- requirements
Module: issuer

---
 rtl/issuer_pkg.sv | 38 +++
 rtl/issuer_cond_eval.sv | 43 ++++
 rtl/issuer.sv | 97 +++++++++
 tb/tb_issuer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/issuer_pkg.sv
// Shared types and constants for the conditional instruction issuer.
// The issuer's optional cond-field rewrite is controlled by ISSUER_COND_STRIP_EN.
package issuer_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } condCode_e;

  typedef enum logic {
    IDLE = 1'b0,
    EVAL = 1'b1
  } issuerState_e;

  // Bit positions inside the 4-bit NZCV nibble taken from cpsr[31:28].
  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  // ARM "MOV r0, r0", used as the architectural no-op.
  localparam logic [31:0] NOP_DEFAULT = 32'hE1A00000;

endpackage

// File: rtl/issuer_cond_eval.sv
// Combinational ARM condition-code decode: pass is high when cond holds for nzcv.
module cond_eval
  import issuer_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n;
  logic z;
  logic c;
  logic v;

  assign n = nzcv[NZCV_N];
  assign z = nzcv[NZCV_Z];
  assign c = nzcv[NZCV_C];
  assign v = nzcv[NZCV_V];

  always_comb begin
    pass = 1'b0;
    case (condCode_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/issuer.sv
// Two-phase conditional instruction issuer: replaces condition-failed words with NOP_WORD.
// Define ISSUER_COND_STRIP_EN to rewrite the cond field of passed words to AL.
module issuer
  import issuer_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        readyIn,
  input  logic [31:0] dataIn,
  input  logic        triggerIn,
  input  logic [31:0] cpsr,
  output logic        readyOut,
  output logic [31:0] dataOut,
  output logic        triggerOut
);

  // Handshake: triggerIn/triggerOut are two-phase (each toggle is one event);
  // a request is taken only in IDLE with readyIn high, and exactly one
  // triggerOut toggle answers it one cycle later with dataOut already valid.

  issuerState_e state;
  issuerState_e stateNext;

  logic        trigSeen;
  logic [31:0] capWord;
  logic [3:0]  capNzcv;
  logic        pending;
  logic        capture;
  logic        issue;
  logic        pass;
  logic [31:0] passWord;
  logic [31:0] issueWord;
  logic [27:0] unusedCpsr;

  assign unusedCpsr = cpsr[27:0];
  assign pending    = (triggerIn != trigSeen);

  cond_eval u_condEval (
    .cond (capWord[31:28]),
    .nzcv (capNzcv),
    .pass (pass)
  );

`ifdef ISSUER_COND_STRIP_EN
  assign passWord = {COND_AL, capWord[27:0]};
`else
  assign passWord = capWord;
`endif

  assign issueWord = pass ? passWord : NOP_WORD;

  always_comb begin
    stateNext = state;
    readyOut  = 1'b0;
    capture   = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        readyOut = 1'b1;
        if (pending && readyIn) begin
          capture   = 1'b1;
          stateNext = EVAL;
        end
      end
      EVAL: begin
        issue     = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      trigSeen   <= 1'b0;
      capWord    <= '0;
      capNzcv    <= '0;
      dataOut    <= '0;
      triggerOut <= 1'b0;
    end else begin
      state <= stateNext;
      if (capture) begin
        capWord  <= dataIn;
        capNzcv  <= cpsr[31:28];
        trigSeen <= triggerIn;
      end
      if (issue) begin
        dataOut    <= issueWord;
        triggerOut <= ~triggerOut;
      end
    end
  end

endmodule

// File: tb/tb_issuer.sv
// Self-checking bench for issuer: directed vectors, stalls, busy toggles, resets, random traffic.
module tb_issuer;

  localparam logic [31:0] NOP = 32'hE1A00000;

  logic        clk = 1'b0;
  logic        rst;
  logic        readyIn;
  logic [31:0] dataIn;
  logic        triggerIn;
  logic [31:0] cpsr;
  logic        readyOut;
  logic [31:0] dataOut;
  logic        triggerOut;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  issuer dut (
    .clk        (clk),
    .rst        (rst),
    .readyIn    (readyIn),
    .dataIn     (dataIn),
    .triggerIn  (triggerIn),
    .cpsr       (cpsr),
    .readyOut   (readyOut),
    .dataOut    (dataOut),
    .triggerOut (triggerOut)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Reference: ARM condition rules evaluated on named flags.
  function automatic logic [31:0] model(input logic [31:0] word, input logic [31:0] status);
    bit n, z, c, v, ok;
    n = status[31];
    z = status[30];
    c = status[29];
    v = status[28];
    case (word[31:28])
      4'h0: ok = z;
      4'h1: ok = !z;
      4'h2: ok = c;
      4'h3: ok = !c;
      4'h4: ok = n;
      4'h5: ok = !n;
      4'h6: ok = v;
      4'h7: ok = !v;
      4'h8: ok = c && !z;
      4'h9: ok = !c || z;
      4'hA: ok = (n == v);
      4'hB: ok = (n != v);
      4'hC: ok = !z && (n == v);
      4'hD: ok = z || (n != v);
      4'hE: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    if (!ok) return NOP;
`ifdef ISSUER_COND_STRIP_EN
    return {4'hE, word[27:0]};
`else
    return word;
`endif
  endfunction

  // driver: present a request at a negedge; stall cycles hold readyIn low first
  task automatic send(input string name, input logic [31:0] word, input logic [31:0] status,
                      input int stall);
    logic prevT;
    logic [31:0] expv;
    @(negedge clk);
    prevT     = triggerOut;
    dataIn    = word;
    cpsr      = status;
    triggerIn = ~triggerIn;
    readyIn   = (stall == 0);
    exp_q.push_back(model(word, status));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checks++;
      if (readyOut !== 1'b1 || triggerOut !== prevT) begin
        errors++;
        $display("FAIL %s stall%0d readyOut=%b triggerOut=%b required readyOut=1 triggerOut=%b",
                 name, i, readyOut, triggerOut, prevT);
      end
      if (i == stall - 1) readyIn = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (readyOut !== 1'b0 || triggerOut !== prevT) begin
      errors++;
      $display("FAIL %s capture readyOut=%b triggerOut=%b required readyOut=0 triggerOut=%b",
               name, readyOut, triggerOut, prevT);
    end
    @(negedge clk);
    expv = exp_q.pop_front();
    checks++;
    if (triggerOut !== ~prevT || dataOut !== expv || readyOut !== 1'b1) begin
      errors++;
      $display("FAIL %s issue triggerOut=%b dataOut=%h readyOut=%b required %b %h 1",
               name, triggerOut, dataOut, readyOut, ~prevT, expv);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; readyIn = 1'b0; dataIn = '0; triggerIn = 1'b0; cpsr = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (readyOut !== 1'b1 || dataOut !== 32'h0 || triggerOut !== 1'b0) begin
      errors++;
      $display("FAIL reset readyOut=%b dataOut=%h triggerOut=%b required 1 00000000 0",
               readyOut, dataOut, triggerOut);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    send("eq_pass", 32'h00ff00ff, 32'h40ff00ff, 0);
    send("eq_fail", 32'h00f0f0f0, 32'h00ff00ff, 0);
    send("ne_pass", 32'h10ff00ff, 32'h00ff00ff, 0);
    send("ne_fail", 32'h10f0f0f0, 32'h40ff00ff, 0);
    send("ge_pass", 32'hA1234567, 32'h90000000, 0);
    send("lt_fail", 32'hB1234567, 32'h90000000, 0);
    send("nv_nop",  32'hF0000001, 32'hF0000000, 0);
    send("hi_pass", 32'h8abcdef0, 32'h20000000, 0);
    send("gt_fail", 32'hC0000011, 32'h40000000, 0);
  endtask

  task automatic test_ready_hold();
    send("ready_hold", 32'h5aa55aa5, 32'h00000000, 5);
  endtask

  task automatic test_back_to_back();
    logic prevT;
    logic [31:0] e1, e2;
    @(negedge clk);
    prevT = triggerOut;
    dataIn = 32'h01111111; cpsr = 32'h40000000; triggerIn = ~triggerIn; readyIn = 1'b1;
    e1 = model(dataIn, cpsr);
    @(negedge clk);  // in EVAL: a second toggle stays pending
    dataIn = 32'h12222222; cpsr = 32'h40000000; triggerIn = ~triggerIn;
    e2 = model(dataIn, cpsr);
    @(negedge clk);
    checks++;
    if (triggerOut !== ~prevT || dataOut !== e1) begin
      errors++;
      $display("FAIL busy_first triggerOut=%b dataOut=%h required %b %h",
               triggerOut, dataOut, ~prevT, e1);
    end
    @(negedge clk);
    checks++;
    if (readyOut !== 1'b0 || dataOut !== e1) begin
      errors++;
      $display("FAIL busy_recapture readyOut=%b dataOut=%h required 0 %h", readyOut, dataOut, e1);
    end
    @(negedge clk);
    checks++;
    if (triggerOut !== prevT || dataOut !== e2) begin
      errors++;
      $display("FAIL busy_second triggerOut=%b dataOut=%h required %b %h",
               triggerOut, dataOut, prevT, e2);
    end
  endtask

  task automatic test_reset_in_eval();
    @(negedge clk);
    dataIn = 32'hE0000042; cpsr = '0; triggerIn = ~triggerIn; readyIn = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    triggerIn = 1'b0;
    @(negedge clk);
    checks++;
    if (triggerOut !== 1'b0 || dataOut !== 32'h0 || readyOut !== 1'b1) begin
      errors++;
      $display("FAIL reset_eval triggerOut=%b dataOut=%h readyOut=%b required 0 00000000 1",
               triggerOut, dataOut, readyOut);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (triggerOut !== 1'b0 || readyOut !== 1'b1) begin
      errors++;
      $display("FAIL reset_abandon triggerOut=%b readyOut=%b required 0 1", triggerOut, readyOut);
    end
  endtask

  task automatic test_reset_pending();
    logic [31:0] expv;
    rst = 1'b1; triggerIn = 1'b1; readyIn = 1'b1;
    dataIn = 32'h00ff00ff; cpsr = 32'h40000000;
    expv = model(dataIn, cpsr);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (readyOut !== 1'b0) begin
      errors++;
      $display("FAIL reset_pending_capture readyOut=%b required 0", readyOut);
    end
    @(negedge clk);
    checks++;
    if (triggerOut !== 1'b1 || dataOut !== expv) begin
      errors++;
      $display("FAIL reset_pending_issue triggerOut=%b dataOut=%h required 1 %h",
               triggerOut, dataOut, expv);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      send("random", $urandom, $urandom, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ready_hold();
    test_back_to_back();
    test_random();
    test_reset_in_eval();
    test_reset_pending();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
